wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback-side producer for the compute-unit register files and scoreboard.
//  Collects completions from N_SRC execution sources (ALU0/1, LSU, FPU, VALU, ...).
//  Arbitrates each register class onto its fixed writeback ports: 3 scalar, 2 FP, 2 vector.
//  Registered wb_* outputs drive both the register-file write ports and the scoreboard busy-clear inputs.
// PARAMETERS
//  N_SRC   6   number of completion sources (2..8)
//  DATA_W  32  writeback payload width
// PORTS
//  clk               in   1             core clock
//  rst_n             in   1             asynchronous active-low reset
//  flush_all         in   1             global flush; suppresses grants, clears outputs
//  src_valid         in   N_SRC         completion request per source
//  src_ready         out  N_SRC         request granted this cycle (combinational)
//  src_class         in   2*N_SRC       00 scalar, 01 FP, 10/11 vector
//  src_rd            in   5*N_SRC       destination register
//  src_data          in   DATA_W*N_SRC  result payload
//  wb_scalar_valid   out  3             scalar WB port valid
//  wb_scalar_rd      out  15            5 bits per port
//  wb_scalar_data    out  3*DATA_W
//  wb_fp_valid       out  2             FP WB port valid
//  wb_fp_rd          out  10
//  wb_fp_data        out  2*DATA_W
//  wb_vec_valid      out  2             vector WB port valid
//  wb_vec_rd         out  10
//  wb_vec_data       out  2*DATA_W
//  stat_conflict     out  3*32          per-class stall counters (WB_ARB_STATS_EN only)
// BEHAVIOUR
//  Handshake
//   - Source transfers on src_valid && src_ready.
//   - A source holds valid, class, rd and data stable until ready.
//   - src_ready never depends on another source's ready.
//  Arbitration, per class c with P_c ports (3/2/2)
//   - Scan sources from ptr_c upward, modulo N_SRC.
//   - Grant the first P_c valid requests of class c.
//   - The k-th grant maps to port k.
//  Same-rd guard
//   - A later request in scan order whose rd equals an already-granted rd of the same class is not granted that cycle.
//   - Result: no two ports of a class carry the same rd in one cycle.
//  Pointer update
//   - ptr_c <= (last granted index + 1) mod N_SRC when class c grants.
//   - ptr_c is unchanged otherwise.
//   - Reset value of every ptr_c is 0.
//  Latency
//   - Grant in cycle T; wb_*_valid/rd/data are registered and visible in T+1.
//   - Ports not granted in T show valid=0 in T+1; rd and data are held, don't-care.
//  Scalar x0
//   - Request is granted (consumed) and occupies its port.
//   - Its output valid is forced to 0.
//  flush_all
//   - In cycle T: all src_ready=0 and no grant.
//   - In T+1: all wb_*_valid=0; pointers hold.
//   - A pending source is dropped by its owner, not here.
//  Reset
//   - All wb_*_valid=0, rd=0, data=0, ptr=0, stat_conflict=0, src_ready=0.
//   - Reset mid-traffic discards granted-but-unwritten results.
//  No internal buffering: a transfer completes in exactly one cycle or stalls at the source.
// CONFIGURATION
//  WB_ARB_STATS_EN defined
//   - stat_conflict[c] counts cycles with at least one valid, ungranted class-c request while flush_all=0.
//   - Counters are 32-bit and saturate at 32'hFFFF_FFFF.
//  WB_ARB_STATS_EN undefined
//   - stat_conflict is tied to 0 and no counter flops are built.
// STRUCTURE
//  Package cu_wb_pkg
//   - reg_class_e: RC_SCALAR=2'b00, RC_FP=2'b01, RC_VEC=2'b10.
//   - Constants WB_S_PORTS=3, WB_F_PORTS=2, WB_V_PORTS=2.
//   - Struct wb_port_t {valid, rd, data}.
//  Sub-module wb_rr_picker
//   - Parameterised by N_SRC and P.
//   - Rotating multi-grant picker with same-rd guard.
//   - Instantiated once per class; the top holds the pointers and output flops.
// TESTING
//  1. Single ALU scalar x5 with data 32'h1234 in cycle 0
//     -> src_ready=1 in cycle 0; cycle 1 wb_scalar_valid=3'b001, rd0=5, data0=32'h1234.
//  2. Four scalar requests from src0..3 (rd 1..4), ptr=0
//     -> src0..2 granted to ports 0..2; src3 stalls; ptr=3.
//     -> Next cycle src3 is granted to port 0.
//  3. src1 and src4 both FP f7 in the same cycle
//     -> only src1 granted; src4 granted the next cycle.
//     -> Never two FP ports carry rd=7 together.
//  4. Scalar x0 request
//     -> src_ready=1; next cycle wb_scalar_valid=0.
//  5. Vector request on src2 with flush_all=1 in cycle T
//     -> src_ready=0; wb_vec_valid=0 in T+1.
//     -> The held request is granted in T+1 once flush deasserts.
//  6. WB_ARB_STATS_EN: 10 cycles of 3 FP requests
//     -> stat_conflict[FP]=10.
//     -> Mid-test rst_n low clears all counters and outputs asynchronously.

Source files
------------

// File: rtl/cu_wb_pkg.sv
// ============================================================================
// Module      : cu_wb_pkg
// Description : Shared types and constants for the compute-unit writeback
//               arbiter: register-class encoding, per-class writeback port
//               counts and the writeback port descriptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_wb_pkg;

   // Destination register class carried with every completion.
   // 2'b11 is also treated as vector by the arbiter.
   typedef enum logic [1:0] {
      RC_SCALAR = 2'b00,
      RC_FP     = 2'b01,
      RC_VEC    = 2'b10
   } reg_class_e;

   // Fixed writeback port counts per register class
   localparam int WB_S_PORTS = 3;
   localparam int WB_F_PORTS = 2;
   localparam int WB_V_PORTS = 2;

   // Default writeback payload width
   localparam int WB_DATA_W = 32;

   // One writeback port as seen by a register file / scoreboard
   typedef struct packed {
      logic                 valid;
      logic [4:0]           rd;
      logic [WB_DATA_W-1:0] data;
   } wb_port_t;

endpackage

`default_nettype wire

// File: rtl/wb_rr_picker.sv
// ============================================================================
// Module      : wb_rr_picker
// Description : Rotating multi-grant picker for one register class. Scans
//               requesters from ptr upward (mod N_SRC) and grants the first P
//               requests whose rd differs from every rd already granted in the
//               same scan. The k-th grant is steered to port k.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_picker #(
   parameter int N_SRC = 6,
   parameter int P     = 3,
   parameter int IDX_W = 3
) (
   input  logic [N_SRC-1:0]   req,
   input  logic [5*N_SRC-1:0] rd,
   input  logic [IDX_W-1:0]   ptr,
   output logic [N_SRC-1:0]   grant,
   output logic [P-1:0]       port_valid,
   output logic [P*IDX_W-1:0] port_idx,
   output logic [IDX_W-1:0]   last_idx,
   output logic               any_grant
);

   logic [4:0] w_rd_a [N_SRC];

   // Unpack the destination registers for indexed access
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         w_rd_a[i] = rd[i*5 +: 5];
      end
   end

   // Rotating scan: first P distinct-rd requests win, in scan order
   always_comb begin
      logic [4:0]       taken_rd [P];
      logic [IDX_W-1:0] idx;
      int               cnt;
      int               pos;
      logic             dup;

      grant      = '0;
      port_valid = '0;
      port_idx   = '0;
      last_idx   = ptr;
      any_grant  = 1'b0;
      cnt        = 0;
      pos        = 0;
      idx        = '0;
      dup        = 1'b0;
      for (int j = 0; j < P; j++) begin
         taken_rd[j] = 5'd0;
      end

      for (int k = 0; k < N_SRC; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N_SRC) begin
            pos = pos - N_SRC;
         end
         idx = IDX_W'(pos);
         if (req[idx] && (cnt < P)) begin
            // A later request duplicating an already-granted rd waits a cycle
            dup = 1'b0;
            for (int j = 0; j < P; j++) begin
               if ((j < cnt) && (taken_rd[j] == w_rd_a[idx])) begin
                  dup = 1'b1;
               end
            end
            if (!dup) begin
               grant[idx] = 1'b1;
               for (int p = 0; p < P; p++) begin
                  if (p == cnt) begin
                     port_valid[p]              = 1'b1;
                     port_idx[p*IDX_W +: IDX_W] = idx;
                     taken_rd[p]                = w_rd_a[idx];
                  end
               end
               last_idx  = idx;
               any_grant = 1'b1;
               cnt       = cnt + 1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter for the compute-unit register files and
//               scoreboard. Collects completions from N_SRC sources and
//               arbitrates each register class onto its fixed writeback ports
//               (3 scalar, 2 FP, 2 vector). Outputs are registered.
//               Optional feature macro: WB_ARB_STATS_EN (per-class stall
//               counters on stat_conflict; tied to zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
   import cu_wb_pkg::*;
#(
   parameter int N_SRC  = 6,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_all,
   input  logic [N_SRC-1:0]         src_valid,
   output logic [N_SRC-1:0]         src_ready,
   input  logic [2*N_SRC-1:0]       src_class,
   input  logic [5*N_SRC-1:0]       src_rd,
   input  logic [DATA_W*N_SRC-1:0]  src_data,
   output logic [WB_S_PORTS-1:0]    wb_scalar_valid,
   output logic [5*WB_S_PORTS-1:0]  wb_scalar_rd,
   output logic [WB_S_PORTS*DATA_W-1:0] wb_scalar_data,
   output logic [WB_F_PORTS-1:0]    wb_fp_valid,
   output logic [5*WB_F_PORTS-1:0]  wb_fp_rd,
   output logic [WB_F_PORTS*DATA_W-1:0] wb_fp_data,
   output logic [WB_V_PORTS-1:0]    wb_vec_valid,
   output logic [5*WB_V_PORTS-1:0]  wb_vec_rd,
   output logic [WB_V_PORTS*DATA_W-1:0] wb_vec_data,
   output logic [3*32-1:0]          stat_conflict
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   // Pointer advance: one past the last granted source, wrapping at N_SRC
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] last);
      if (int'(last) >= N_SRC - 1) begin
         return '0;
      end
      return last + 1'b1;
   endfunction

   logic [N_SRC-1:0]  w_req_s, w_req_f, w_req_v;
   logic [N_SRC-1:0]  w_gnt_s, w_gnt_f, w_gnt_v;
   logic [4:0]        w_rd_a   [N_SRC];
   logic [DATA_W-1:0] w_data_a [N_SRC];

   logic [WB_S_PORTS-1:0]       w_pv_s;
   logic [WB_F_PORTS-1:0]       w_pv_f;
   logic [WB_V_PORTS-1:0]       w_pv_v;
   logic [WB_S_PORTS*IDX_W-1:0] w_pidx_s;
   logic [WB_F_PORTS*IDX_W-1:0] w_pidx_f;
   logic [WB_V_PORTS*IDX_W-1:0] w_pidx_v;
   logic [IDX_W-1:0]            w_last_s, w_last_f, w_last_v;
   logic                        w_any_s, w_any_f, w_any_v;

   logic [IDX_W-1:0] ptr_s_q, ptr_s_d, ptr_f_q, ptr_f_d, ptr_v_q, ptr_v_d;

   logic [WB_S_PORTS-1:0]        s_valid_q, s_valid_d;
   logic [5*WB_S_PORTS-1:0]      s_rd_q, s_rd_d;
   logic [WB_S_PORTS*DATA_W-1:0] s_data_q, s_data_d;
   logic [WB_F_PORTS-1:0]        f_valid_q, f_valid_d;
   logic [5*WB_F_PORTS-1:0]      f_rd_q, f_rd_d;
   logic [WB_F_PORTS*DATA_W-1:0] f_data_q, f_data_d;
   logic [WB_V_PORTS-1:0]        v_valid_q, v_valid_d;
   logic [5*WB_V_PORTS-1:0]      v_rd_q, v_rd_d;
   logic [WB_V_PORTS*DATA_W-1:0] v_data_q, v_data_d;

   // Split requests per class; flush and reset suppress every request
   always_comb begin
      w_req_s = '0;
      w_req_f = '0;
      w_req_v = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_rd_a[i]   = src_rd[i*5 +: 5];
         w_data_a[i] = src_data[i*DATA_W +: DATA_W];
         if (src_valid[i] && rst_n && !flush_all) begin
            if (src_class[2*i +: 2] == RC_SCALAR) begin
               w_req_s[i] = 1'b1;
            end else if (src_class[2*i +: 2] == RC_FP) begin
               w_req_f[i] = 1'b1;
            end else begin
               w_req_v[i] = 1'b1;
            end
         end
      end
   end

   wb_rr_picker #(.N_SRC(N_SRC), .P(WB_S_PORTS), .IDX_W(IDX_W)) u_pick_s (
      .req(w_req_s), .rd(src_rd), .ptr(ptr_s_q), .grant(w_gnt_s),
      .port_valid(w_pv_s), .port_idx(w_pidx_s), .last_idx(w_last_s), .any_grant(w_any_s)
   );

   wb_rr_picker #(.N_SRC(N_SRC), .P(WB_F_PORTS), .IDX_W(IDX_W)) u_pick_f (
      .req(w_req_f), .rd(src_rd), .ptr(ptr_f_q), .grant(w_gnt_f),
      .port_valid(w_pv_f), .port_idx(w_pidx_f), .last_idx(w_last_f), .any_grant(w_any_f)
   );

   wb_rr_picker #(.N_SRC(N_SRC), .P(WB_V_PORTS), .IDX_W(IDX_W)) u_pick_v (
      .req(w_req_v), .rd(src_rd), .ptr(ptr_v_q), .grant(w_gnt_v),
      .port_valid(w_pv_v), .port_idx(w_pidx_v), .last_idx(w_last_v), .any_grant(w_any_v)
   );

   // Each source belongs to exactly one class, so the grants can be merged
   assign src_ready = w_gnt_s | w_gnt_f | w_gnt_v;

   // Next-state for ports and pointers; ungranted ports keep rd/data
   always_comb begin
      logic [IDX_W-1:0] idx;
      idx       = '0;
      s_valid_d = '0;
      s_rd_d    = s_rd_q;
      s_data_d  = s_data_q;
      f_valid_d = '0;
      f_rd_d    = f_rd_q;
      f_data_d  = f_data_q;
      v_valid_d = '0;
      v_rd_d    = v_rd_q;
      v_data_d  = v_data_q;

      for (int p = 0; p < WB_S_PORTS; p++) begin
         if (w_pv_s[p]) begin
            idx = w_pidx_s[p*IDX_W +: IDX_W];
            // x0 writes are consumed but never signalled as valid
            s_valid_d[p]                = (w_rd_a[idx] != 5'd0);
            s_rd_d[p*5 +: 5]            = w_rd_a[idx];
            s_data_d[p*DATA_W +: DATA_W] = w_data_a[idx];
         end
      end
      for (int p = 0; p < WB_F_PORTS; p++) begin
         if (w_pv_f[p]) begin
            idx = w_pidx_f[p*IDX_W +: IDX_W];
            f_valid_d[p]                = 1'b1;
            f_rd_d[p*5 +: 5]            = w_rd_a[idx];
            f_data_d[p*DATA_W +: DATA_W] = w_data_a[idx];
         end
      end
      for (int p = 0; p < WB_V_PORTS; p++) begin
         if (w_pv_v[p]) begin
            idx = w_pidx_v[p*IDX_W +: IDX_W];
            v_valid_d[p]                = 1'b1;
            v_rd_d[p*5 +: 5]            = w_rd_a[idx];
            v_data_d[p*DATA_W +: DATA_W] = w_data_a[idx];
         end
      end

      ptr_s_d = w_any_s ? next_ptr(w_last_s) : ptr_s_q;
      ptr_f_d = w_any_f ? next_ptr(w_last_f) : ptr_f_q;
      ptr_v_d = w_any_v ? next_ptr(w_last_v) : ptr_v_q;
   end

   // Writeback port and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid_q <= '0;
         s_rd_q    <= '0;
         s_data_q  <= '0;
         f_valid_q <= '0;
         f_rd_q    <= '0;
         f_data_q  <= '0;
         v_valid_q <= '0;
         v_rd_q    <= '0;
         v_data_q  <= '0;
         ptr_s_q   <= '0;
         ptr_f_q   <= '0;
         ptr_v_q   <= '0;
      end else begin
         s_valid_q <= s_valid_d;
         s_rd_q    <= s_rd_d;
         s_data_q  <= s_data_d;
         f_valid_q <= f_valid_d;
         f_rd_q    <= f_rd_d;
         f_data_q  <= f_data_d;
         v_valid_q <= v_valid_d;
         v_rd_q    <= v_rd_d;
         v_data_q  <= v_data_d;
         ptr_s_q   <= ptr_s_d;
         ptr_f_q   <= ptr_f_d;
         ptr_v_q   <= ptr_v_d;
      end
   end

   assign wb_scalar_valid = s_valid_q;
   assign wb_scalar_rd    = s_rd_q;
   assign wb_scalar_data  = s_data_q;
   assign wb_fp_valid     = f_valid_q;
   assign wb_fp_rd        = f_rd_q;
   assign wb_fp_data      = f_data_q;
   assign wb_vec_valid    = v_valid_q;
   assign wb_vec_rd       = v_rd_q;
   assign wb_vec_data     = v_data_q;

`ifdef WB_ARB_STATS_EN
   logic [2:0]  w_stall;
   logic [31:0] stat_q [3];
   logic [31:0] stat_d [3];

   // A class stalls when any of its (unflushed) requests went ungranted
   always_comb begin
      w_stall[0] = |(w_req_s & ~w_gnt_s);
      w_stall[1] = |(w_req_f & ~w_gnt_f);
      w_stall[2] = |(w_req_v & ~w_gnt_v);
      for (int c = 0; c < 3; c++) begin
         stat_d[c] = stat_q[c];
         if (w_stall[c] && (stat_q[c] != 32'hFFFF_FFFF)) begin
            stat_d[c] = stat_q[c] + 32'd1;
         end
      end
   end

   // Saturating stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            stat_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            stat_q[c] <= stat_d[c];
         end
      end
   end

   assign stat_conflict = {stat_q[2], stat_q[1], stat_q[0]};
`else
   assign stat_conflict = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter (N_SRC=6,
//               DATA_W=32). Honours WB_ARB_STATS_EN for the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

   localparam int N  = 6;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush_all;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [2*N-1:0]  src_class;
   logic [5*N-1:0]  src_rd;
   logic [DW*N-1:0] src_data;
   logic [2:0]      wb_scalar_valid;
   logic [14:0]     wb_scalar_rd;
   logic [3*DW-1:0] wb_scalar_data;
   logic [1:0]      wb_fp_valid;
   logic [9:0]      wb_fp_rd;
   logic [2*DW-1:0] wb_fp_data;
   logic [1:0]      wb_vec_valid;
   logic [9:0]      wb_vec_rd;
   logic [2*DW-1:0] wb_vec_data;
   logic [95:0]     stat_conflict;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_fp_stat;
   logic [5:0]  rr_seq [3];

   wb_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .flush_all(flush_all),
      .src_valid(src_valid), .src_ready(src_ready), .src_class(src_class),
      .src_rd(src_rd), .src_data(src_data),
      .wb_scalar_valid(wb_scalar_valid), .wb_scalar_rd(wb_scalar_rd),
      .wb_scalar_data(wb_scalar_data),
      .wb_fp_valid(wb_fp_valid), .wb_fp_rd(wb_fp_rd), .wb_fp_data(wb_fp_data),
      .wb_vec_valid(wb_vec_valid), .wb_vec_rd(wb_vec_rd), .wb_vec_data(wb_vec_data),
      .stat_conflict(stat_conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input int i, input logic v, input logic [1:0] c,
                      input logic [4:0] rd, input logic [31:0] d);
      src_valid[i]        = v;
      src_class[2*i +: 2] = c;
      src_rd[5*i +: 5]    = rd;
      src_data[DW*i +: DW] = d;
   endtask

   task automatic clear_all();
      src_valid = '0;
      src_class = '0;
      src_rd    = '0;
      src_data  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_all();
      flush_all = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rr_seq[0] = 6'b000011;
      rr_seq[1] = 6'b000101;
      rr_seq[2] = 6'b000110;
`ifdef WB_ARB_STATS_EN
      exp_fp_stat = 32'd10;
`else
      exp_fp_stat = 32'd0;
`endif

      // Reset state, with a request present that must not be granted
      rst_n     = 1'b0;
      flush_all = 1'b0;
      clear_all();
      put(0, 1'b1, 2'b00, 5'd5, 32'h1);
      tick();
      check("rst_ready", src_ready, 6'b0);
      check("rst_s_valid", wb_scalar_valid, 3'b0);
      check("rst_s_rd", wb_scalar_rd, 15'd0);
      check("rst_s_data", wb_scalar_data, 96'd0);
      check("rst_f_valid", wb_fp_valid, 2'b0);
      check("rst_v_valid", wb_vec_valid, 2'b0);
      check("rst_stat", stat_conflict, 96'd0);
      do_reset();

      // 1: single scalar x5
      put(0, 1'b1, 2'b00, 5'd5, 32'h1234);
      #1 check("t1_ready", src_ready, 6'b000001);
      tick();
      put(0, 1'b0, 2'b00, 5'd0, 32'h0);
      check("t1_s_valid", wb_scalar_valid, 3'b001);
      check("t1_s_rd0", wb_scalar_rd[4:0], 5'd5);
      check("t1_s_data0", wb_scalar_data[31:0], 32'h1234);
      check("t1_f_valid", wb_fp_valid, 2'b00);

      // 2: four scalar requests, three ports
      do_reset();
      for (int i = 0; i < 4; i++) put(i, 1'b1, 2'b00, 5'(i + 1), 32'hA0 + 32'(i));
      #1 check("t2_ready_a", src_ready, 6'b000111);
      tick();
      check("t2_s_valid_a", wb_scalar_valid, 3'b111);
      check("t2_s_rd_a", wb_scalar_rd, {5'd3, 5'd2, 5'd1});
      check("t2_s_data0", wb_scalar_data[31:0], 32'hA0);
      check("t2_s_data2", wb_scalar_data[95:64], 32'hA2);
      for (int i = 0; i < 3; i++) put(i, 1'b0, 2'b00, 5'd0, 32'h0);
      #1 check("t2_ready_b", src_ready, 6'b001000);
      tick();
      put(3, 1'b0, 2'b00, 5'd0, 32'h0);
      check("t2_s_valid_b", wb_scalar_valid, 3'b001);
      check("t2_s_rd_b", wb_scalar_rd[4:0], 5'd4);
      check("t2_s_data_b", wb_scalar_data[31:0], 32'hA3);
      tick();
      check("t2_s_idle", wb_scalar_valid, 3'b000);

      // 3: same FP rd from two sources
      do_reset();
      put(1, 1'b1, 2'b01, 5'd7, 32'hB1);
      put(4, 1'b1, 2'b01, 5'd7, 32'hB4);
      #1 check("t3_ready_a", src_ready, 6'b000010);
      tick();
      put(1, 1'b0, 2'b00, 5'd0, 32'h0);
      check("t3_f_valid_a", wb_fp_valid, 2'b01);
      check("t3_f_rd_a", wb_fp_rd[4:0], 5'd7);
      check("t3_f_data_a", wb_fp_data[31:0], 32'hB1);
      #1 check("t3_ready_b", src_ready, 6'b010000);
      tick();
      put(4, 1'b0, 2'b00, 5'd0, 32'h0);
      check("t3_f_valid_b", wb_fp_valid, 2'b01);
      check("t3_f_data_b", wb_fp_data[31:0], 32'hB4);

      // 3b: duplicate is skipped, next distinct rd takes the second port
      do_reset();
      put(1, 1'b1, 2'b01, 5'd7, 32'hC1);
      put(2, 1'b1, 2'b01, 5'd9, 32'hC2);
      put(3, 1'b1, 2'b01, 5'd7, 32'hC3);
      #1 check("t3b_ready", src_ready, 6'b000110);
      tick();
      clear_all();
      check("t3b_f_valid", wb_fp_valid, 2'b11);
      check("t3b_f_rd", wb_fp_rd, {5'd9, 5'd7});

      // 4: scalar x0 occupies a port but is not signalled
      do_reset();
      put(2, 1'b1, 2'b00, 5'd0, 32'h55);
      put(3, 1'b1, 2'b00, 5'd8, 32'h66);
      #1 check("t4_ready", src_ready, 6'b001100);
      tick();
      clear_all();
      check("t4_s_valid", wb_scalar_valid, 3'b010);
      check("t4_s_rd1", wb_scalar_rd[9:5], 5'd8);
      check("t4_s_data1", wb_scalar_data[63:32], 32'h66);

      // 5: flush blocks grants and clears outputs; held request goes after
      do_reset();
      put(0, 1'b1, 2'b00, 5'd6, 32'h66);
      #1 check("t5_ready_pre", src_ready, 6'b000001);
      tick();
      put(0, 1'b0, 2'b00, 5'd0, 32'h0);
      put(2, 1'b1, 2'b11, 5'd10, 32'hC2);
      flush_all = 1'b1;
      check("t5_s_valid_pre", wb_scalar_valid, 3'b001);
      #1 check("t5_ready_flush", src_ready, 6'b000000);
      tick();
      check("t5_s_valid_flush", wb_scalar_valid, 3'b000);
      check("t5_v_valid_flush", wb_vec_valid, 2'b00);
      flush_all = 1'b0;
      #1 check("t5_ready_post", src_ready, 6'b000100);
      tick();
      clear_all();
      check("t5_v_valid", wb_vec_valid, 2'b01);
      check("t5_v_rd", wb_vec_rd[4:0], 5'd10);
      check("t5_v_data", wb_vec_data[31:0], 32'hC2);

      // 6: ten cycles of three FP requests on two ports
      do_reset();
      put(0, 1'b1, 2'b01, 5'd1, 32'hD0);
      put(1, 1'b1, 2'b01, 5'd2, 32'hD1);
      put(2, 1'b1, 2'b01, 5'd3, 32'hD2);
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1 check($sformatf("t6_ready_%0d", cyc), src_ready, rr_seq[cyc % 3]);
         tick();
      end
      check("t6_stat_fp", stat_conflict[63:32], exp_fp_stat);
      check("t6_stat_s", stat_conflict[31:0], 32'd0);
      check("t6_stat_v", stat_conflict[95:64], 32'd0);
      check("t6_f_valid", wb_fp_valid, 2'b11);

      // Asynchronous reset in the middle of a cycle
      #2 rst_n = 1'b0;
      #1;
      check("t6_arst_stat", stat_conflict, 96'd0);
      check("t6_arst_f_valid", wb_fp_valid, 2'b00);
      check("t6_arst_f_rd", wb_fp_rd, 10'd0);
      check("t6_arst_f_data", wb_fp_data, 64'd0);
      check("t6_arst_ready", src_ready, 6'b0);
      clear_all();
      tick();
      rst_n = 1'b1;

      // Pointer back at 0 after reset: src0 FP granted to port 0
      put(0, 1'b1, 2'b01, 5'd4, 32'hE0);
      put(5, 1'b1, 2'b01, 5'd5, 32'hE5);
      #1 check("t7_ready", src_ready, 6'b100001);
      tick();
      clear_all();
      check("t7_f_rd", wb_fp_rd, {5'd5, 5'd4});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
